vip_matrix_3x3_gen: RTL and testbench



---
 rtl/vip_pkg.sv | 10 +
 rtl/vip_matrix_3x3_gen_if.sv | 26 ++
 rtl/vip_line_buf_2x.sv | 19 +
 rtl/vip_matrix_3x3_gen.sv | 93 +++++++++
 tb/tb_vip_matrix_3x3_gen.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/vip_pkg.sv
// vip_pkg: pixel width and address-width helper shared across the vip pipeline
package vip_pkg;
   localparam int PIX_W = 8;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/vip_matrix_3x3_gen_if.sv
// vip_matrix_3x3_gen_if: Y pixel stream in, 3x3 window stream out, both with vsync/href/clken framing
interface vip_matrix_3x3_gen_if;
   import vip_pkg::*;
   logic             pre_frame_vsync;
   logic             pre_frame_href;
   logic             pre_frame_clken;
   logic [PIX_W-1:0] pre_img_Y;
   logic             matrix_frame_vsync;
   logic             matrix_frame_href;
   logic             matrix_frame_clken;
   logic [PIX_W-1:0] matrix_p11, matrix_p12, matrix_p13;
   logic [PIX_W-1:0] matrix_p21, matrix_p22, matrix_p23;
   logic [PIX_W-1:0] matrix_p31, matrix_p32, matrix_p33;
   modport master (
      output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_Y,
      input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
      input  matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
      input  matrix_p31, matrix_p32, matrix_p33
   );
   modport slave (
      input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_Y,
      output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
      output matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
      output matrix_p31, matrix_p32, matrix_p33
   );
endinterface

// File: rtl/vip_line_buf_2x.sv
// vip_line_buf_2x: read-first simple dual-port RAM holding {line-2, line-1} per column
module vip_line_buf_2x #(
   parameter int DEPTH = 640,
   parameter int AW    = 10,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data
);
   logic [DW-1:0] r_mem [DEPTH];
   always_ff @(posedge clk) begin
      o_rd_data <= r_mem[i_rd_addr];
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end
endmodule

// File: rtl/vip_matrix_3x3_gen.sv
// vip_matrix_3x3_gen: 3x3 neighbourhood generator over two buffered lines, zero-padded at top and left
module vip_matrix_3x3_gen
   import vip_pkg::*;
#(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480
) (
   input logic                  clk,
   input logic                  rst,
   vip_matrix_3x3_gen_if.slave  io_vid
);
   localparam int AW = clog2(IMG_HDISP);
   localparam int CW = clog2(IMG_HDISP + 1);
   localparam int RW = clog2(IMG_VDISP + 1);
   localparam logic [CW-1:0] H_MAX = CW'(IMG_HDISP);
   localparam logic [RW-1:0] V_MAX = RW'(IMG_VDISP);

   logic [1:0]                 r_vsync_d, r_href_d, r_clken_d;
   logic [CW-1:0]              r_col_cnt;
   logic [RW-1:0]              r_row_cnt;
   logic                       r_frm_vld, r_acc_d1;
   logic [AW-1:0]              r_addr_d1;
   logic [PIX_W-1:0]           r_pix_d1;
   logic [2:0][2:0][PIX_W-1:0] r_win;
   logic                       w_acc, w_vs_rise, w_hr_fall, w_row0, w_row1;
   logic [AW-1:0]              w_rd_addr;
   logic [2*PIX_W-1:0]         w_rd_data;
   logic [2:0][PIX_W-1:0]      w_new;

   assign w_acc     = io_vid.pre_frame_clken & io_vid.pre_frame_href & (r_col_cnt < H_MAX);
   assign w_rd_addr = w_acc ? r_col_cnt[AW-1:0] : '0;
   assign w_vs_rise = io_vid.pre_frame_vsync & ~r_vsync_d[0];
   assign w_hr_fall = ~io_vid.pre_frame_href & r_href_d[0];
   // until a vsync restarts counting after reset, the frame is treated as row 0
   assign w_row0    = ~r_frm_vld | (r_row_cnt == '0);
   assign w_row1    = r_frm_vld & (r_row_cnt == RW'(1));
   assign w_new[0]  = (w_row0 | w_row1) ? '0 : w_rd_data[2*PIX_W-1:PIX_W];
   assign w_new[1]  = w_row0 ? '0 : w_rd_data[PIX_W-1:0];
   assign w_new[2]  = r_pix_d1;

   vip_line_buf_2x #(.DEPTH(IMG_HDISP), .AW(AW), .DW(2*PIX_W)) u_line_buf (
      .clk       (clk),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data),
      .i_wr_en   (r_acc_d1),
      .i_wr_addr (r_addr_d1),
      .i_wr_data ({w_rd_data[PIX_W-1:0], r_pix_d1})
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vsync_d <= '0;
         r_href_d  <= '0;
         r_clken_d <= '0;
         r_col_cnt <= '0;
         r_row_cnt <= '0;
         r_frm_vld <= 1'b0;
         r_acc_d1  <= 1'b0;
         r_addr_d1 <= '0;
         r_pix_d1  <= '0;
         r_win     <= '0;
      end else begin
         r_vsync_d <= {r_vsync_d[0], io_vid.pre_frame_vsync};
         r_href_d  <= {r_href_d[0], io_vid.pre_frame_href};
         r_clken_d <= {r_clken_d[0], io_vid.pre_frame_clken};
         r_col_cnt <= io_vid.pre_frame_href ? r_col_cnt + CW'(w_acc) : '0;
         r_acc_d1  <= w_acc;
         r_addr_d1 <= w_rd_addr;
         r_pix_d1  <= io_vid.pre_img_Y;
         if (w_vs_rise) begin
            r_row_cnt <= '0;
            r_frm_vld <= 1'b1;
         end else if (w_hr_fall & r_frm_vld & (r_row_cnt != V_MAX)) begin
            r_row_cnt <= r_row_cnt + RW'(1);
         end
         if (!r_href_d[0]) r_win <= '0;
         else if (r_acc_d1) r_win <= {{w_new[2], r_win[2][2:1]}, {w_new[1], r_win[1][2:1]}, {w_new[0], r_win[0][2:1]}};
      end
   end

   assign io_vid.matrix_frame_vsync = r_vsync_d[1];
   assign io_vid.matrix_frame_href  = r_href_d[1];
   assign io_vid.matrix_frame_clken = r_clken_d[1];
   assign io_vid.matrix_p11 = r_href_d[1] ? r_win[0][0] : '0;
   assign io_vid.matrix_p12 = r_href_d[1] ? r_win[0][1] : '0;
   assign io_vid.matrix_p13 = r_href_d[1] ? r_win[0][2] : '0;
   assign io_vid.matrix_p21 = r_href_d[1] ? r_win[1][0] : '0;
   assign io_vid.matrix_p22 = r_href_d[1] ? r_win[1][1] : '0;
   assign io_vid.matrix_p23 = r_href_d[1] ? r_win[1][2] : '0;
   assign io_vid.matrix_p31 = r_href_d[1] ? r_win[2][0] : '0;
   assign io_vid.matrix_p32 = r_href_d[1] ? r_win[2][1] : '0;
   assign io_vid.matrix_p33 = r_href_d[1] ? r_win[2][2] : '0;
endmodule

// File: tb/tb_vip_matrix_3x3_gen.sv
// tb_vip_matrix_3x3_gen: scoreboard bench, image-level window model vs the 3x3 generator
module tb_vip_matrix_3x3_gen;
   localparam int H = 4;
   localparam int V = 4;
   typedef struct {
      logic [71:0] w;
      int          tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vip_matrix_3x3_gen_if vid();
   vip_matrix_3x3_gen #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (.clk(clk), .rst(rst), .io_vid(vid));

   exp_t       q[$];
   int         n_vec = 0, n_err = 0;
   bit         pend = 0, m_fv = 0, p_hr = 0, p_vs = 0;
   int         m_row = 0, m_col = 0, frm = -1;
   logic [7:0] l2 [H] = '{default: 8'h00};
   logic [7:0] l1 [H] = '{default: 8'h00};
   logic [7:0] cur [H] = '{default: 8'h00};

   // window around column c of the current line, from the stored image lines
   function automatic logic [71:0] win(int c);
      logic [71:0] w;
      logic [7:0]  v;
      int          x;
      w = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            x = c - 2 + j;
            if (x < 0 || (i == 0 && (!m_fv || m_row < 2)) || (i == 1 && (!m_fv || m_row < 1))) v = 8'h00;
            else v = (i == 0) ? l2[x] : (i == 1) ? l1[x] : cur[x];
            w = {w[63:0], v};
         end
      end
      return w;
   endfunction

   task automatic drive(bit vs, bit hr, bit ce, logic [7:0] y, bit rs);
      exp_t e;
      @(posedge clk);
      #1;
      rst = rs;
      vid.pre_frame_vsync = vs;
      vid.pre_frame_href  = hr;
      vid.pre_frame_clken = ce;
      vid.pre_img_Y       = y;
      if (pend) begin
         q.delete();
         pend = 0;
      end
      if (rs) begin
         m_fv = 0; m_col = 0; p_hr = 0; p_vs = 0; pend = 1;
      end else begin
         if (vs && !p_vs) begin
            m_row = 0; m_fv = 1; frm++;
         end else if (p_hr && !hr && m_fv && m_row < V) begin
            m_row++;
         end
         if (p_hr && !hr) begin
            l2 = l1;
            l1 = cur;
         end
         if (!hr) m_col = 0;
         else if (ce) begin
            if (m_col < H) begin
               cur[m_col] = y;
               e.w = win(m_col);
               e.tag = frm * 100 + m_row * 10 + m_col;
               m_col++;
            end else begin
               e.w = win(H - 1);
               e.tag = -1;
            end
            q.push_back(e);
         end
         p_hr = hr;
         p_vs = vs;
      end
   endtask

   task automatic send_line(int r, int mode, bit do_rst);
      int c, tgt;
      bit ce, tog;
      c = 0;
      tog = 1;
      tgt = H + ((mode == 2) ? int'($urandom_range(0, 1)) : 0);
      while (c < tgt) begin
         ce = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
         tog = ~tog;
         drive(0, 1, ce, (mode == 2) ? 8'($urandom) : 8'(8'h80 + 16 * r + c), do_rst && c == 1 && ce);
         if (ce) c++;
      end
      repeat ((mode == 2) ? $urandom_range(1, 3) : 2) drive(0, 0, (mode == 2) && ($urandom_range(0, 1) == 1), 8'h00, 0);
   endtask

   task automatic send_frame(int mode, int rst_row);
      repeat (2) drive(1, 0, 0, 8'h00, 0);
      repeat (2) drive(0, 0, 0, 8'h00, 0);
      for (int r = 0; r < V; r++) send_line(r, mode, r == rst_row);
   endtask

   logic [2:0] h_in [2] = '{3'b000, 3'b000};
   bit         h_rs [2] = '{1'b1, 1'b1};

   always @(negedge clk) begin : mon
      logic [2:0]  fo, fe;
      logic [71:0] dw, dexp;
      exp_t        e;
      fo = {vid.matrix_frame_vsync, vid.matrix_frame_href, vid.matrix_frame_clken};
      fe = (h_rs[0] || h_rs[1]) ? 3'b000 : h_in[1];
      n_vec++;
      if (fo !== fe) begin
         n_err++;
         $display("FAIL framing {vsync,href,clken} got %b want %b at %0t", fo, fe, $time);
      end
      h_in[1] = h_in[0];
      h_rs[1] = h_rs[0];
      h_in[0] = {vid.pre_frame_vsync, vid.pre_frame_href, vid.pre_frame_clken};
      h_rs[0] = rst;
      dw = {vid.matrix_p11, vid.matrix_p12, vid.matrix_p13, vid.matrix_p21, vid.matrix_p22,
            vid.matrix_p23, vid.matrix_p31, vid.matrix_p32, vid.matrix_p33};
      if (!vid.matrix_frame_href) begin
         n_vec++;
         if (dw !== 72'h0) begin
            n_err++;
            $display("FAIL idle_zero window got %h want 0 at %0t", dw, $time);
         end
      end else if (vid.matrix_frame_clken) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL underflow window got %h want none at %0t", dw, $time);
         end else begin
            e = q.pop_front();
            if (dw !== e.w) begin
               n_err++;
               $display("FAIL window tag %0d got %h want %h at %0t", e.tag, dw, e.w, $time);
            end
            if (e.tag == 22 || e.tag == 1 || e.tag == 10 || e.tag == 103) begin
               dexp = (e.tag == 22) ? 72'h80_81_82_90_91_92_A0_A1_A2 :
                      (e.tag == 1)  ? 72'h00_00_00_00_00_00_00_80_81 :
                      (e.tag == 10) ? 72'h00_00_00_00_00_80_00_00_90 :
                                      72'h00_00_00_00_00_00_81_82_83;
               n_vec++;
               if (dw !== dexp) begin
                  n_err++;
                  $display("FAIL directed tag %0d got %h want %h", e.tag, dw, dexp);
               end
            end
         end
      end
   end

   initial begin
      vid.pre_frame_vsync = 1'b0;
      vid.pre_frame_href  = 1'b0;
      vid.pre_frame_clken = 1'b0;
      vid.pre_img_Y       = 8'h00;
      repeat (3) drive(0, 0, 0, 8'h00, 1);
      send_frame(0, -1);
      send_frame(0, -1);
      send_frame(1, -1);
      send_frame(0, 2);
      send_frame(0, -1);
      repeat (4) send_frame(2, -1);
      repeat (6) drive(0, 0, 0, 8'h00, 0);
      @(negedge clk);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL leftover windows got %0d want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
